uart_tx_sched: RTL and testbench

- Round-robin scheduler that shares one UART transmitter between two byte-stream requesters, e.g. CPU log path and debug/trace master.
- Owns the UART controller's memory-mapped port; sequences one byte at a time:
  - poll TX busy
  - write TX data
  - pulse TX enable
  - guard wait
- Sits between the requesters and the UART controller instance in the peripheral subsystem.

---
 rtl/uart_tx_sched_pkg.sv | 26 ++
 rtl/uart_tx_sched_arb.sv | 33 +++
 rtl/uart_tx_sched.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_sched.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_sched_pkg.sv
// Shared UART register map, TX_CTRL bit positions and scheduler state encoding.
package uart_tx_sched_pkg;

  localparam logic [31:0] UART_TX_DATA_OFS = 32'h0000_0000;
  localparam logic [31:0] UART_TX_CTRL_OFS = 32'h0000_0004;
  localparam logic [31:0] UART_RX_DATA_OFS = 32'h0000_0008;
  localparam logic [31:0] UART_RX_CTRL_OFS = 32'h0000_000C;
  localparam logic [31:0] UART_DIVIDER_OFS = 32'h0000_0010;

  localparam int unsigned TX_CTRL_EN_BIT   = 1;
  localparam int unsigned TX_CTRL_BUSY_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL,
    ST_WR_DATA,
    ST_WR_CTRL,
    ST_GUARD
  } sched_state_e;

  // TX_CTRL word that starts a transmission.
  function automatic logic [31:0] tx_ctrl_enable_word();
    return 32'(1) << TX_CTRL_EN_BIT;
  endfunction

endpackage

// File: rtl/uart_tx_sched_arb.sv
// Two-way round-robin arbiter: combinational grant, registered last-winner pointer.
module uart_rr_arb2
  import uart_tx_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid_i,
  input  logic       accept_i,
  output logic       grant_o
);

  logic rr_last_q;

  // Prefer the requester that did not win last; fall back to the sole valid one.
  always_comb begin
    grant_o = 1'b0;
    if (rr_last_q) begin
      grant_o = req_valid_i[0] ? 1'b0 : 1'b1;
    end else begin
      grant_o = req_valid_i[1] ? 1'b1 : 1'b0;
    end
  end

  // Pointer resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= 1'b1;
    end else if (accept_i) begin
      rr_last_q <= grant_o;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin byte scheduler driving one UART transmitter over its register port.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter logic [31:0] UART_BASE_ADDR = 32'h4000_0000,
  parameter int unsigned GUARD_CYCLES   = 4,
  parameter logic [15:0] POLL_TIMEOUT   = 16'd65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        sched_busy,
  output logic        grant_id,
  output logic        err_timeout
);

  localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYCLES - 1);

  sched_state_e state_q, state_d;
  logic [7:0]   byte_q, byte_d;
  logic         grant_q, grant_d;
  logic [15:0]  poll_cnt_q, poll_cnt_d;
  logic [3:0]   guard_cnt_q, guard_cnt_d;
  logic         err_q, err_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic [31:0]  mem_wdata_q, mem_wdata_d;
  logic         mem_we_q, mem_we_d;
  logic         mem_re_q, mem_re_d;

  logic any_valid;
  logic accept;
  logic arb_grant;
  logic tx_busy;
  logic poll_hit;
  logic rdata_unused;

  assign any_valid = req0_valid | req1_valid;
  assign accept    = (state_q == ST_IDLE) && any_valid;
  assign tx_busy   = mem_rdata[TX_CTRL_BUSY_BIT];
  assign poll_hit  = (POLL_TIMEOUT != '0) &&
                     (({1'b0, poll_cnt_q} + 17'd1) == {1'b0, POLL_TIMEOUT});
  assign rdata_unused = ^mem_rdata;

  uart_rr_arb2 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i ({req1_valid, req0_valid}),
    .accept_i    (accept),
    .grant_o     (arb_grant)
  );

  // Ready is combinational in IDLE; gating with rst_n keeps it low while reset is held.
  assign req0_ready  = rst_n && accept && !arb_grant;
  assign req1_ready  = rst_n && accept &&  arb_grant;
  assign sched_busy  = (state_q != ST_IDLE);
  assign grant_id    = grant_q;
  assign err_timeout = err_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;
  assign mem_re      = mem_re_q;

  // Next-state logic: accept, poll busy with timeout, two writes, guard wait.
  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    grant_d     = grant_q;
    poll_cnt_d  = poll_cnt_q;
    guard_cnt_d = guard_cnt_q;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          byte_d  = arb_grant ? req1_data : req0_data;
          grant_d = arb_grant;
          state_d = ST_POLL;
        end
      end
      ST_POLL: begin
        if (!tx_busy) begin
          poll_cnt_d = '0;
          state_d    = ST_WR_DATA;
        end else if (poll_hit) begin
          poll_cnt_d = '0;
          err_d      = 1'b1;
          state_d    = ST_IDLE;
        end else if (poll_cnt_q != '1) begin
          poll_cnt_d = poll_cnt_q + 16'd1;
        end
      end
      ST_WR_DATA: state_d = ST_WR_CTRL;
      ST_WR_CTRL: begin
        guard_cnt_d = '0;
        state_d     = ST_GUARD;
      end
      ST_GUARD: begin
        if (guard_cnt_q == GUARD_LAST) begin
          guard_cnt_d = '0;
          state_d     = ST_IDLE;
        end else begin
          guard_cnt_d = guard_cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus outputs decoded from the next state so the registered strobes line up with the state.
  always_comb begin
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    case (state_d)
      ST_POLL: begin
        mem_re_d   = 1'b1;
        mem_addr_d = UART_BASE_ADDR + UART_TX_CTRL_OFS;
      end
      ST_WR_DATA: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = UART_BASE_ADDR + UART_TX_DATA_OFS;
        mem_wdata_d = {24'h0, byte_d};
      end
      ST_WR_CTRL: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = UART_BASE_ADDR + UART_TX_CTRL_OFS;
        mem_wdata_d = tx_ctrl_enable_word();
      end
      default: ;
    endcase
  end

  // State, counters and bus registers; reset aborts any byte in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      byte_q      <= '0;
      grant_q     <= 1'b0;
      poll_cnt_q  <= '0;
      guard_cnt_q <= '0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      grant_q     <= grant_d;
      poll_cnt_q  <= poll_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: write scoreboard, per-scenario tasks, small UART model with serial decoder.
module tb_uart_tx_sched;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main DUT (default parameters)
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0]  req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re, sched_busy, grant_id, err_timeout;
  logic        busy_force = 1'b0;
  logic        uart_model_en = 1'b0;

  // timeout DUT (POLL_TIMEOUT = 8)
  logic        t0_valid = 1'b0, t1_valid = 1'b0;
  logic [7:0]  t0_data = '0, t1_data = '0;
  logic        t0_ready, t1_ready;
  logic [31:0] t_addr, t_wdata, t_rdata;
  logic        t_we, t_re, t_sbusy, t_grant, t_err;
  logic        t_busy = 1'b0;

  int total = 0;
  int bad = 0;
  int re_cycles = 0;
  int dec_count = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  dec_q[$];

  // UART transmitter model (divider 4)
  logic        m_busy;
  logic [9:0]  m_shift;
  logic [7:0]  m_data;
  logic [3:0]  m_bits;
  logic [1:0]  m_div;
  int          m_overwrite;
  logic        tx_line;

  assign mem_rdata = {31'h0, uart_model_en ? m_busy : busy_force};
  assign t_rdata   = {31'h0, t_busy};
  assign tx_line   = m_busy ? m_shift[0] : 1'b1;

  uart_tx_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .sched_busy(sched_busy), .grant_id(grant_id),
    .err_timeout(err_timeout)
  );

  uart_tx_sched #(.POLL_TIMEOUT(16'd8)) dut_to (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(t0_valid), .req0_data(t0_data), .req0_ready(t0_ready),
    .req1_valid(t1_valid), .req1_data(t1_data), .req1_ready(t1_ready),
    .mem_addr(t_addr), .mem_wdata(t_wdata), .mem_we(t_we), .mem_re(t_re),
    .mem_rdata(t_rdata), .sched_busy(t_sbusy), .grant_id(t_grant),
    .err_timeout(t_err)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_shift <= '1; m_data <= '0; m_bits <= '0; m_div <= '0; m_overwrite <= 0;
    end else if (uart_model_en) begin
      if (mem_we && mem_addr == BASE) begin
        m_data <= mem_wdata[7:0];
        if (m_busy) m_overwrite <= m_overwrite + 1;
      end
      if (mem_we && mem_addr == BASE + 32'h4 && mem_wdata[1]) begin
        if (m_busy) begin
          m_overwrite <= m_overwrite + 1;
        end else begin
          m_busy <= 1'b1; m_shift <= {1'b1, m_data, 1'b0}; m_bits <= '0; m_div <= '0;
        end
      end else if (m_busy) begin
        if (m_div == 2'd3) begin
          m_div   <= '0;
          m_shift <= {1'b1, m_shift[9:1]};
          if (m_bits == 4'd9) m_busy <= 1'b0;
          else m_bits <= m_bits + 4'd1;
        end else begin
          m_div <= m_div + 2'd1;
        end
      end
    end
  end

  // serial decoder: mid-bit sampling, compares each frame against the expected byte queue
  initial forever begin
    logic [7:0] b;
    logic       stopb;
    logic [7:0] eb;
    @(negedge clk);
    if (uart_model_en && rst_n && tx_line == 1'b0) begin
      repeat (2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (4) @(negedge clk);
        b[k] = tx_line;
      end
      repeat (4) @(negedge clk);
      stopb = tx_line;
      total++;
      dec_count++;
      if (dec_q.size() == 0) begin
        bad++; $display("FAIL serial_unexpected got=%h stop=%b required=none", b, stopb);
      end else begin
        eb = dec_q.pop_front();
        if ({stopb, b} !== {1'b1, eb}) begin
          bad++; $display("FAIL serial_byte got=%h stop=%b required=%h stop=1", b, stopb, eb);
        end
      end
    end
  end

  // bus monitor for the main DUT: strobe exclusivity, idle-zero bus, write scoreboard, no timeout
  initial forever begin
    logic [63:0] e;
    @(negedge clk);
    if (rst_n) begin
      total++;
      if (mem_we && mem_re) begin
        bad++; $display("FAIL strobe_excl we=%b re=%b required=not both", mem_we, mem_re);
      end
      if (!mem_we && !mem_re) begin
        total++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
          bad++; $display("FAIL bus_idle_zero addr=%h wdata=%h required=0/0", mem_addr, mem_wdata);
        end
      end
      if (mem_re) re_cycles++;
      if (mem_we) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL write_unexpected addr=%h wdata=%h required=none", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({mem_addr, mem_wdata} !== e) begin
            bad++; $display("FAIL write addr=%h wdata=%h required=%h/%h", mem_addr, mem_wdata, e[63:32], e[31:0]);
          end
        end
      end
      total++;
      if (err_timeout !== 1'b0) begin
        bad++; $display("FAIL main_err got=%b required=0", err_timeout);
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    exp_q.push_back({BASE, 24'h0, b});
    exp_q.push_back({BASE + 32'h4, 32'h2});
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; t0_valid = 1'b0; t1_valid = 1'b0;
    busy_force = 1'b0; t_busy = 1'b0; uart_model_en = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // present a byte on requester `which` from a negedge, hold until ready, drop after the accept edge
  task automatic send(input logic which, input logic [7:0] d);
    bit seen = 1'b0;
    if (which) begin req1_data = d; req1_valid = 1'b1; end
    else begin req0_data = d; req0_valid = 1'b1; end
    for (int i = 0; i < 200 && !seen; i++) begin
      #1;
      if (which ? req1_ready : req0_ready) seen = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL send_timeout req=%0d ready=0 required=1", which);
    end
    @(posedge clk); #1;
    if (which) req1_valid = 1'b0; else req0_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!sched_busy && exp_q.size() == 0 && dec_q.size() == 0 && !m_busy) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++; $display("FAIL %s_drain pending_writes=%0d pending_bytes=%0d required=0", name, exp_q.size(), dec_q.size());
    end
  endtask

  task automatic test_reset();
    req0_valid = 1'b1; req0_data = 8'h99;
    repeat (2) @(negedge clk);
    total++;
    if ({mem_addr, mem_wdata, mem_we, mem_re} !== 66'h0) begin
      bad++; $display("FAIL reset_bus addr=%h wdata=%h we=%b re=%b required=0", mem_addr, mem_wdata, mem_we, mem_re);
    end
    total++;
    if ({req0_ready, req1_ready, sched_busy, grant_id, err_timeout} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b required=00000",
                      {req0_ready, req1_ready, sched_busy, grant_id, err_timeout});
    end
    total++;
    if ({t0_ready, t_we, t_re, t_sbusy, t_err} !== 5'b0) begin
      bad++; $display("FAIL reset_to got=%b required=00000", {t0_ready, t_we, t_re, t_sbusy, t_err});
    end
    req0_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [66:0] exp_c;
    busy_force = 1'b0;
    push_byte(8'h41);
    req0_data = 8'h41; req0_valid = 1'b1;
    #1;
    total++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      bad++; $display("FAIL single_ready got=%b required=01", {req1_ready, req0_ready});
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    // {we, re, addr, wdata, sched_busy} per cycle after the accept
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      case (i)
        1:       exp_c = {1'b0, 1'b1, BASE + 32'h4, 32'h0, 1'b1};
        2:       exp_c = {1'b1, 1'b0, BASE, 32'h41, 1'b1};
        3:       exp_c = {1'b1, 1'b0, BASE + 32'h4, 32'h2, 1'b1};
        8:       exp_c = {1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
        default: exp_c = {1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
      endcase
      total++;
      if ({mem_we, mem_re, mem_addr, mem_wdata, sched_busy} !== exp_c) begin
        bad++; $display("FAIL single_cycle%0d got=%h required=%h", i,
                        {mem_we, mem_re, mem_addr, mem_wdata, sched_busy}, exp_c);
      end
    end
    total++;
    if (grant_id !== 1'b0 || exp_q.size() != 0) begin
      bad++; $display("FAIL single_end grant=%b pending=%0d required=0/0", grant_id, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic eg[4];
    int   got = 0;
    eg = '{1'b0, 1'b1, 1'b0, 1'b1};
    apply_reset();
    push_byte(8'h30); push_byte(8'h31); push_byte(8'h30); push_byte(8'h31);
    req0_data = 8'h30; req1_data = 8'h31;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 100 && got < 4; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        total++;
        if ({req1_ready, req0_ready} !== (eg[got] ? 2'b10 : 2'b01)) begin
          bad++; $display("FAIL rr_grant%0d got=%b required=%0d", got, {req1_ready, req0_ready}, eg[got]);
        end
        total++;
        if (grant_id !== ((got == 0) ? 1'b0 : eg[got - 1])) begin
          bad++; $display("FAIL rr_grant_id%0d got=%b", got, grant_id);
        end
        got++;
        if (got == 4) begin
          @(posedge clk); #1;
          req0_valid = 1'b0; req1_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    total++;
    if (got != 4) begin
      bad++; $display("FAIL rr_count got=%0d required=4", got);
    end
    wait_idle("rr");
  endtask

  task automatic test_poll_wait();
    int polls = 0;
    apply_reset();
    busy_force = 1'b1;
    push_byte(8'h5A);
    send(1'b0, 8'h5A);
    if (mem_re) polls++;
    for (int i = 0; i < 40 && sched_busy; i++) begin
      @(negedge clk);
      if (mem_re) begin
        polls++;
        // busy seen high on 10 polls, low on the 11th
        if (polls == 11) busy_force = 1'b0;
      end
    end
    total++;
    if (polls != 11) begin
      bad++; $display("FAIL poll_cycles got=%0d required=11", polls);
    end
    wait_idle("poll");
  endtask

  task automatic test_timeout();
    int polls = 0, writes = 0, errs = 0, at_err = -1;
    logic busy_at_err = 1'b1;
    logic [31:0] wd = '0;
    bit seen = 1'b0;
    apply_reset();
    t_busy = 1'b1;
    t0_data = 8'h77; t0_valid = 1'b1;
    #1;
    total++;
    if (t0_ready !== 1'b1) begin
      bad++; $display("FAIL to_accept got=%b required=1", t0_ready);
    end
    @(posedge clk); #1;
    t0_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (t_re) polls++;
      if (t_we) writes++;
      if (t_err) begin errs++; at_err = polls; busy_at_err = t_sbusy; end
    end
    total++;
    if (errs != 1 || at_err != 8 || polls != 8) begin
      bad++; $display("FAIL to_pulse errs=%0d polls_at_err=%0d polls=%0d required=1/8/8", errs, at_err, polls);
    end
    total++;
    if (writes != 0 || busy_at_err !== 1'b0) begin
      bad++; $display("FAIL to_drop writes=%0d busy=%b required=0/0", writes, busy_at_err);
    end
    t_busy = 1'b0;
    t0_data = 8'h78; t0_valid = 1'b1;
    #1;
    total++;
    if (t0_ready !== 1'b1) begin
      bad++; $display("FAIL to_next_accept got=%b required=1", t0_ready);
    end
    @(posedge clk); #1;
    t0_valid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (t_we && t_addr == BASE) begin seen = 1'b1; wd = t_wdata; end
    end
    total++;
    if (!seen || wd !== 32'h78) begin
      bad++; $display("FAIL to_next_write seen=%b wdata=%h required=1/00000078", seen, wd);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_guard();
    bit hit = 1'b0;
    apply_reset();
    push_byte(8'h12);
    send(1'b0, 8'h12);
    for (int i = 0; i < 20 && !hit; i++) begin
      if (mem_we && mem_addr == BASE + 32'h4) hit = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    total++;
    if (!hit || sched_busy !== 1'b1) begin
      bad++; $display("FAIL guard_reach hit=%b busy=%b required=1/1", hit, sched_busy);
    end
    #2;
    rst_n = 1'b0;
    req0_data = 8'h21; req1_data = 8'h22;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    total++;
    if ({req0_ready, req1_ready, mem_addr, mem_wdata, mem_we, mem_re, sched_busy, grant_id, err_timeout} !== 71'h0) begin
      bad++; $display("FAIL async_reset busy=%b ready=%b%b we=%b re=%b required=all 0",
                      sched_busy, req1_ready, req0_ready, mem_we, mem_re);
    end
    exp_q.delete();
    push_byte(8'h21);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      bad++; $display("FAIL post_reset_grant got=%b required=01", {req1_ready, req0_ready});
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle("guard_reset");
  endtask

  task automatic test_uart();
    apply_reset();
    uart_model_en = 1'b1;
    dec_q.push_back(8'h55); dec_q.push_back(8'hA3);
    push_byte(8'h55); push_byte(8'hA3);
    dec_count = 0;
    send(1'b0, 8'h55);
    send(1'b0, 8'hA3);
    wait_idle("uart");
    total++;
    if (dec_count != 2 || m_overwrite != 0) begin
      bad++; $display("FAIL uart_line decoded=%0d overwrites=%0d required=2/0", dec_count, m_overwrite);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_poll_wait();
    test_timeout();
    test_reset_guard();
    test_uart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
